// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with clear, load, wrap/saturate mode,
// a one-cycle terminal-count pulse and a sticky overflow flag.
module counter_updown_mod #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MOD_MAX  = (2 ** WIDTH) - 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count_en,
    input  logic             count_valid,
    input  logic             dir,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD_MAX);

    logic             step;
    logic [WIDTH-1:0] count_next;
    logic             tc_next;
    logic             ovf_next;

    assign step = count_en && count_valid;

    // Next-state selection: clear > load > step > hold.
    always_comb begin
        count_next = o_count;
        tc_next    = 1'b0;
        ovf_next   = o_ovf;
        if (clear) begin
            count_next = '0;
            ovf_next   = 1'b0;
        end else if (load) begin
            count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (step) begin
            if (dir) begin
                if (o_count >= MAX_VAL) begin
                    count_next = SATURATE ? MAX_VAL : '0;
                    tc_next    = 1'b1;
                    ovf_next   = 1'b1;
                end else begin
                    count_next = o_count + WIDTH'(1);
                end
            end else begin
                if (o_count == '0) begin
                    count_next = SATURATE ? '0 : MAX_VAL;
                    tc_next    = 1'b1;
                    ovf_next   = 1'b1;
                end else begin
                    count_next = o_count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_count <= '0;
            o_tc    <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            o_count <= count_next;
            o_tc    <= tc_next;
            o_ovf   <= ovf_next;
        end
    end

    assign o_zero = (o_count == '0);

endmodule
